mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data width of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; the memory has 2**ADDR_WIDTH words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req[1:0]  input  2  SHALL carry one access request per requester; bit i belongs to requester i.
REQ-006 we[1:0]  input  2  SHALL mark requester i's request as a write (1) or a read (0).
REQ-007 addr0, addr1  input  ADDR_WIDTH each  SHALL carry the requester word addresses.
REQ-008 wdata0, wdata1  input  DATA_WIDTH each  SHALL carry the requester write data.
REQ-009 gnt[1:0]  output  2  SHALL pulse for one cycle when requester i's command is accepted.
REQ-010 done[1:0]  output  2  SHALL pulse for one cycle when requester i's access completes.
REQ-011 rdata  output  DATA_WIDTH  SHALL carry read data; it is valid only while done[i] is high for a read.
REQ-012 mem_read, mem_write  output  1 each  SHALL drive the memory read and write strobes.
REQ-013 mem_addr  output  ADDR_WIDTH  SHALL drive the memory address.
REQ-014 mem_wdata  output  DATA_WIDTH  SHALL drive the memory write data.
REQ-015 mem_rdata  input  DATA_WIDTH  SHALL receive memory data_out, which is registered one cycle after the read strobe is sampled.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-017 IDLE: strobes low; if any req is high, gnt[winner] is driven combinationally in that cycle; at the clock edge, winner, we, addr and wdata are latched and the FSM moves to ACCESS.
REQ-018 ACCESS (exactly 1 cycle): mem_read = !we_latched, mem_write = we_latched, mem_addr/mem_wdata = latched values; the FSM then moves to RESP.
REQ-019 mem_read and mem_write SHALL never be high in the same cycle, and SHALL be low in every state other than ACCESS.
REQ-020 RESP: done[owner] = 1 and rdata = mem_rdata; arbitration is evaluated as in IDLE; on a grant the FSM goes directly to ACCESS, otherwise to IDLE.
REQ-021 Latency: a grant in cycle N SHALL give ACCESS in N+1 and done in N+2. Back-to-back throughput SHALL be one access per 2 cycles.
REQ-022 Arbitration SHALL be two-way round-robin: with both req high, the requester not granted most recently wins; with one req high, it wins regardless of priority.
REQ-023 The priority pointer SHALL update only on a grant.
REQ-024 A requester SHALL hold req, we, addr and wdata stable until gnt; after gnt it may change or drop them without affecting the access in flight.
REQ-025 A req dropped before its gnt SHALL have no effect.
REQ-026 A requester that sees done and gnt in the same RESP cycle SHALL have its new command accepted.
REQ-027 gnt SHALL never pulse during ACCESS, and at most one gnt bit SHALL be high per cycle.
REQ-028 For a write, done SHALL pulse, and rdata is don't-care.
REQ-029 Address wrap-around SHALL not apply: addresses pass through unchanged, and all 2**ADDR_WIDTH values are legal.

Reset
REQ-030 While rst_ is low at a clock edge: state becomes IDLE, the priority pointer favours requester 0, and gnt, done, mem_read and mem_write are 0 from the next cycle.
REQ-031 Reset during ACCESS or RESP SHALL abort the access with no done pulse; a write whose ACCESS cycle already completed remains in memory.
REQ-032 mem_addr, mem_wdata and the latched command SHALL reset to 0.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum typedef and the default width constants DATA_WIDTH=8 and ADDR_WIDTH=5.
REQ-034 The round-robin decision SHALL live in sub-module rr_arb2 (inputs req[1:0], ptr, enable; output grant[1:0]); mem_arbiter instantiates it once.

Verification
REQ-035 Single read: memory word 5 = 8'hA5; req[0]=1, we[0]=0, addr0=5 in cycle 1 -> gnt[0] in cycle 1, mem_read in cycle 2, done[0] with rdata=8'hA5 in cycle 3.
REQ-036 Write then read: requester 1 writes 8'h3C to address 31 -> mem_write for exactly 1 cycle, done[1] 2 cycles after gnt; a following read of address 31 returns 8'h3C.
REQ-037 Contention: both req held for 4 grants after reset -> grants in order 0,1,0,1, each 2 cycles apart, with no cycle where both strobes are high.
REQ-038 Back-to-back: requester 0 issues 3 reads of addresses 0,1,2 holding req -> gnt coincides with the previous done, and the done pulses are 2 cycles apart.
REQ-039 Reset mid-operation: rst_=0 during ACCESS of a read -> no done pulse, strobes 0 next cycle, and the next contended grant goes to requester 0.
REQ-040 Dropped request: req[1] high for 1 cycle while an access is in ACCESS, then low -> gnt[1] never asserts, and the FSM returns to IDLE after RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default widths for the memory arbiter.
package mem_arb_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 5;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin decision; ptr selects the favoured requester on contention.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       enable,
   output logic [1:0] grant
);
   assign grant = !enable ? 2'b00 : (&req) ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters onto one single-port memory, one access per two cycles.
module mem_arbiter #(
   parameter int DATA_WIDTH = mem_arb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic [1:0]            gnt,
   output logic [1:0]            done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   import mem_arb_pkg::*;
   state_e                state_q, state_d;
   logic                  ptr_q, ptr_d, owner_q, owner_d, we_q, we_d;
   logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [1:0]            done_q, done_d, grant;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  win;
   // A grant offered while reset is held would never be latched, so it is suppressed.
   rr_arb2 u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .enable (rst_ && state_q != ACCESS),
      .grant  (grant)
   );
   assign win = grant[1];
   always_comb begin
      state_d     = IDLE;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      done_d      = 2'b00;
      if (state_q == ACCESS) begin
         state_d = RESP;
         done_d  = owner_q ? 2'b10 : 2'b01;
      end else if (|grant) begin
         state_d     = ACCESS;
         owner_d     = win;
         we_d        = win ? we[1] : we[0];
         addr_d      = win ? addr1 : addr0;
         wdata_d     = win ? wdata1 : wdata0;
         ptr_d       = !win;
         mem_read_d  = !we_d;
         mem_write_d = we_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         done_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         done_q      <= done_d;
      end
   end
   assign gnt       = grant;
   assign done      = rst_ ? done_q : 2'b00;
   assign rdata     = mem_rdata;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;
   logic       clk, rst_, mem_init;
   logic [1:0] req, we, gnt, done;
   logic [4:0] addr0, addr1, mem_addr;
   logic [7:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
   logic       mem_read, mem_write;
   logic [7:0] mem [32];
   int         checks, passed;

   mem_arbiter dut (
      .clk(clk), .rst_(rst_), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done), .rdata(rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word k preloads to k ^ 8'hA0, so word 5 holds 8'hA5.
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i) ^ 8'hA0;
         mem_rdata <= 8'h00;
      end else begin
         if (mem_write) mem[mem_addr] <= mem_wdata;
         if (mem_read) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_ = 1'b0;
      req = 2'b00;
      tick();
      tick();
      smp();
      checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", gnt); else passed++;
      checks++; if (done !== 2'b00) $display("FAIL reset_done got %b want 00", done); else passed++;
      checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {mem_read, mem_write}); else passed++;
      checks++; if (mem_addr !== 5'd0) $display("FAIL reset_addr got %h want 00", mem_addr); else passed++;
      checks++; if (mem_wdata !== 8'h00) $display("FAIL reset_wdata got %h want 00", mem_wdata); else passed++;
   endtask

   task automatic test_single_read;
      tick();
      rst_ = 1'b1;
      req = 2'b01; we = 2'b00; addr0 = 5'd5;
      smp();
      checks++; if (gnt !== 2'b01) $display("FAIL rd_gnt got %b want 01", gnt); else passed++;
      checks++; if (mem_read !== 1'b0) $display("FAIL rd_early_strobe got %b want 0", mem_read); else passed++;
      tick();
      req = 2'b00; addr0 = 5'd9;
      smp();
      checks++; if ({mem_read, mem_write} !== 2'b10) $display("FAIL rd_access_strobes got %b want 10", {mem_read, mem_write}); else passed++;
      checks++; if (mem_addr !== 5'd5) $display("FAIL rd_access_addr got %0d want 5", mem_addr); else passed++;
      checks++; if (done !== 2'b00) $display("FAIL rd_access_done got %b want 00", done); else passed++;
      tick();
      smp();
      checks++; if (done !== 2'b01) $display("FAIL rd_done got %b want 01", done); else passed++;
      checks++; if (rdata !== 8'hA5) $display("FAIL rd_data got %h want a5", rdata); else passed++;
      checks++; if (mem_read !== 1'b0) $display("FAIL rd_resp_strobe got %b want 0", mem_read); else passed++;
      tick();
      smp();
      checks++; if (done !== 2'b00) $display("FAIL rd_done_pulse got %b want 00", done); else passed++;
   endtask

   task automatic test_write_read;
      tick();
      req = 2'b10; we = 2'b10; addr1 = 5'd31; wdata1 = 8'h3C;
      smp();
      checks++; if (gnt !== 2'b10) $display("FAIL wr_gnt got %b want 10", gnt); else passed++;
      checks++; if (mem_write !== 1'b0) $display("FAIL wr_early_strobe got %b want 0", mem_write); else passed++;
      tick();
      req = 2'b00; we = 2'b00; addr1 = 5'd0; wdata1 = 8'hFF;
      smp();
      checks++; if ({mem_read, mem_write} !== 2'b01) $display("FAIL wr_access_strobes got %b want 01", {mem_read, mem_write}); else passed++;
      checks++; if (mem_addr !== 5'd31) $display("FAIL wr_access_addr got %0d want 31", mem_addr); else passed++;
      checks++; if (mem_wdata !== 8'h3C) $display("FAIL wr_access_wdata got %h want 3c", mem_wdata); else passed++;
      tick();
      smp();
      checks++; if (mem_write !== 1'b0) $display("FAIL wr_resp_strobe got %b want 0", mem_write); else passed++;
      checks++; if (done !== 2'b10) $display("FAIL wr_done got %b want 10", done); else passed++;
      tick();
      req = 2'b10; we = 2'b00; addr1 = 5'd31;
      smp();
      checks++; if (gnt !== 2'b10) $display("FAIL rb_gnt got %b want 10", gnt); else passed++;
      tick();
      req = 2'b00;
      smp();
      checks++; if (mem_read !== 1'b1) $display("FAIL rb_strobe got %b want 1", mem_read); else passed++;
      tick();
      smp();
      checks++; if (done !== 2'b10) $display("FAIL rb_done got %b want 10", done); else passed++;
      checks++; if (rdata !== 8'h3C) $display("FAIL rb_data got %h want 3c", rdata); else passed++;
   endtask

   task automatic test_contention;
      logic [1:0] eg [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      tick();
      rst_ = 1'b0;
      tick();
      tick();
      rst_ = 1'b1;
      req = 2'b11; we = 2'b00; addr0 = 5'd1; addr1 = 5'd2;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick();
         smp();
         checks++; if (gnt !== eg[i]) $display("FAIL cont_gnt[%0d] got %b want %b", i, gnt, eg[i]); else passed++;
         checks++; if (mem_read !== 1'(i % 2)) $display("FAIL cont_read[%0d] got %b want %b", i, mem_read, 1'(i % 2)); else passed++;
         checks++; if (mem_read && mem_write) $display("FAIL cont_both_strobes[%0d] got 11 want not 11", i); else passed++;
      end
      tick();
      req = 2'b00;
      smp();
      checks++; if (gnt !== 2'b00) $display("FAIL cont_drain_gnt got %b want 00", gnt); else passed++;
      tick();
      smp();
      checks++; if (done !== 2'b10) $display("FAIL cont_last_done got %b want 10", done); else passed++;
   endtask

   task automatic test_back_to_back;
      logic [1:0] eg [8] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
      logic [1:0] ed [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      logic [7:0] er [8] = '{8'h00, 8'h00, 8'hA0, 8'h00, 8'hA1, 8'h00, 8'hA2, 8'h00};
      for (int i = 0; i < 8; i++) begin
         tick();
         req = (i < 5) ? 2'b01 : 2'b00;
         we = 2'b00;
         addr0 = (i < 2) ? 5'd0 : (i < 4) ? 5'd1 : 5'd2;
         smp();
         checks++; if (gnt !== eg[i]) $display("FAIL b2b_gnt[%0d] got %b want %b", i, gnt, eg[i]); else passed++;
         checks++; if (done !== ed[i]) $display("FAIL b2b_done[%0d] got %b want %b", i, done, ed[i]); else passed++;
         if (ed[i] != 2'b00) begin
            checks++; if (rdata !== er[i]) $display("FAIL b2b_rdata[%0d] got %h want %h", i, rdata, er[i]); else passed++;
         end
      end
   endtask

   task automatic test_reset_mid;
      tick();
      req = 2'b01; we = 2'b00; addr0 = 5'd3;
      smp();
      checks++; if (gnt !== 2'b01) $display("FAIL rstmid_gnt got %b want 01", gnt); else passed++;
      tick();
      req = 2'b00; rst_ = 1'b0;
      smp();
      checks++; if (mem_read !== 1'b1) $display("FAIL rstmid_access got %b want 1", mem_read); else passed++;
      tick();
      rst_ = 1'b1;
      smp();
      checks++; if (done !== 2'b00) $display("FAIL rstmid_done got %b want 00", done); else passed++;
      checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL rstmid_strobes got %b want 00", {mem_read, mem_write}); else passed++;
      tick();
      req = 2'b11;
      smp();
      checks++; if (gnt !== 2'b01) $display("FAIL rstmid_ptr got %b want 01", gnt); else passed++;
      tick();
      req = 2'b00;
      tick();
   endtask

   task automatic test_drop;
      tick();
      req = 2'b01; we = 2'b00; addr0 = 5'd4;
      smp();
      checks++; if (gnt !== 2'b01) $display("FAIL drop_gnt0 got %b want 01", gnt); else passed++;
      tick();
      req = 2'b10;
      smp();
      checks++; if (gnt !== 2'b00) $display("FAIL drop_access_gnt got %b want 00", gnt); else passed++;
      tick();
      req = 2'b00;
      smp();
      checks++; if (done !== 2'b01) $display("FAIL drop_done got %b want 01", done); else passed++;
      checks++; if (rdata !== 8'hA4) $display("FAIL drop_rdata got %h want a4", rdata); else passed++;
      checks++; if (gnt !== 2'b00) $display("FAIL drop_resp_gnt got %b want 00", gnt); else passed++;
      tick();
      smp();
      checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL drop_idle_strobes got %b want 00", {mem_read, mem_write}); else passed++;
      checks++; if ({gnt, done} !== 4'b0000) $display("FAIL drop_idle_gnt_done got %b want 0000", {gnt, done}); else passed++;
   endtask

   initial begin
      checks = 0; passed = 0;
      mem_init = 1'b0;
      rst_ = 1'b0; req = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      tick();
      mem_init = 1'b1;
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      test_drop();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
